frame_update_sequencer: RTL

Schedules per-frame game-state updates into the vertical blanking interval of the 1024x768@60Hz video timing. On each vertical sync it starts a chain of up to NUM_STAGES update engines (input sampling, paddle/ball motion, collision, score) one after another through start/done handshakes. It enforces a per-stage timeout and a hard deadline at the first visible pixel of the next frame, and reports errors through sticky status flags. It sits between the video timing generator and the game logic, in the 65 MHz pixel clock domain.

---
 rtl/frame_update_sequencer_if.sv | 12 +
 rtl/frame_update_sequencer.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/frame_update_sequencer_if.sv
// Start/done handshake bundle between the frame update sequencer and its update engines.
interface frame_update_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  // stage_start[i] is a one-cycle request. stage_done[i] may be a pulse or a held level.
  // It is looked at only while stage i is being waited on, from the cycle after its start.
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_done;

  modport master (output stage_start, input stage_done);
  modport slave  (input stage_start, output stage_done);
endinterface

// File: rtl/frame_update_sequencer.sv
// Chains the per-frame update engines inside vertical blanking.
// Each stage has a timeout, and the first visible pixel acts as a hard deadline.
module frame_update_sequencer #(
  parameter int   NUM_STAGES    = 4,
  parameter int   STAGE_TIMEOUT = 16384,
  parameter logic POLARITY_VS   = 1'b0
) (
  input  logic                     clk_vga,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     vga_vs,
  input  logic                     vga_blank_n,
  input  logic                     clear_status,
  frame_update_sequencer_if.master stg,
  output logic                     busy,
  output logic                     frame_tick,
  output logic                     abort,
  output logic                     overrun,
  output logic [NUM_STAGES-1:0]    timeout_err,
  output logic [15:0]              frame_cnt,
  output logic [7:0]               skipped_cnt,
  output logic [1:0]               dbg_state
);
  localparam int                IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_STAGES - 1);
  localparam logic [15:0]       TIMER_LOAD = 16'(STAGE_TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [15:0]           timer_q, timer_d;
  logic                  vs_prev_q, blank_prev_q;
  logic [NUM_STAGES-1:0] stage_start_q, stage_start_d;
  logic                  busy_q, busy_d;
  logic                  frame_tick_q, frame_tick_d;
  logic                  abort_q, abort_d;
  logic                  overrun_q, overrun_d;
  logic [NUM_STAGES-1:0] timeout_err_q, timeout_err_d;
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [7:0]            skipped_cnt_q, skipped_cnt_d;

  logic vs_act, trigger, deadline, done_sel;
  logic stage_ok, stage_to, kill;

  assign vs_act   = vga_vs ~^ POLARITY_VS;
  assign trigger  = vs_act & ~vs_prev_q;
  assign deadline = vga_blank_n & ~blank_prev_q;
  assign done_sel = stg.stage_done[idx_q];

  // Edge-detect history resets to 1 so a level already present at reset release is not an edge.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      timer_q       <= '0;
      vs_prev_q     <= 1'b1;
      blank_prev_q  <= 1'b1;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      frame_tick_q  <= 1'b0;
      abort_q       <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_err_q <= '0;
      frame_cnt_q   <= '0;
      skipped_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      vs_prev_q     <= vs_act;
      blank_prev_q  <= vga_blank_n;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      frame_tick_q  <= frame_tick_d;
      abort_q       <= abort_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
      frame_cnt_q   <= frame_cnt_d;
      skipped_cnt_q <= skipped_cnt_d;
    end
  end

  // The deadline outranks done and timeout. Done outranks a timeout landing in the same cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    timer_d  = timer_q;
    stage_ok = 1'b0;
    stage_to = 1'b0;
    kill     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trigger && enable) begin
          state_d = S_START;
          idx_d   = '0;
        end
      end
      S_START: begin
        if (deadline) begin
          kill    = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d = S_WAIT;
          timer_d = TIMER_LOAD;
        end
      end
      S_WAIT: begin
        if (deadline) begin
          kill    = 1'b1;
          state_d = S_IDLE;
        end else begin
          timer_d  = timer_q - 16'd1;
          stage_ok = done_sel;
          stage_to = ~done_sel & (timer_q == 16'd1);
          if (stage_ok || stage_to) begin
            if (idx_q == LAST_IDX) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              state_d = S_START;
            end
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are computed from the next state so that every output leaves a flop.
  always_comb begin
    stage_start_d = '0;
    if (state_d == S_START) stage_start_d[idx_d] = 1'b1;
    busy_d        = (state_d != S_IDLE);
    frame_tick_d  = (state_d == S_DONE);
    frame_cnt_d   = frame_tick_d ? frame_cnt_q + 16'd1 : frame_cnt_q;
    abort_d       = kill;
    overrun_d     = kill | (overrun_q & ~clear_status);
    timeout_err_d = clear_status ? '0 : timeout_err_q;
    if (stage_to) timeout_err_d[idx_q] = 1'b1;
    skipped_cnt_d = clear_status ? 8'd0 : skipped_cnt_q;
    if (trigger && (state_q != S_IDLE) && (skipped_cnt_d != 8'hFF)) begin
      skipped_cnt_d = skipped_cnt_d + 8'd1;
    end
  end

  assign stg.stage_start = stage_start_q;
  assign busy            = busy_q;
  assign frame_tick      = frame_tick_q;
  assign abort           = abort_q;
  assign overrun         = overrun_q;
  assign timeout_err     = timeout_err_q;
  assign frame_cnt       = frame_cnt_q;
  assign skipped_cnt     = skipped_cnt_q;
  assign dbg_state       = state_q;
endmodule
